change_payout_ctrl: RTL and testbench

Payout controller at the output side of the beverage vending FSM. It accepts a dispense request (`d`) and a change amount (`r`, in $1 units) from the vending FSM, then drives the beverage chute and the coin hopper. Each physical action uses a four-phase request/acknowledge handshake. Change is paid greedily with $2 and $1 coins, and a fault is flagged if a mechanism stops responding.

---
 rtl/change_payout_ctrl_if.sv | 36 +++
 rtl/change_payout_ctrl.sv | 150 +++++++++++++++
 tb/tb_change_payout_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/change_payout_ctrl_if.sv
// change_payout_ctrl_if
// Groups the vending-side request, the chute/hopper handshakes and the
// status outputs of the payout controller into a single bundle.
//   d, r        : dispense request and change owed (driven by the environment)
//   vend_ack    : beverage chute acknowledge
//   coin_ack    : coin hopper acknowledge
//   vend_go     : beverage release request
//   pay_two     : eject-$2 request
//   pay_one     : eject-$1 request
//   busy, paid, done, fault : controller status
// Modports: master = environment side, slave = controller side.
interface change_payout_ctrl_if #(
    parameter int CHG_W = 3
);
    logic             d;
    logic [CHG_W-1:0] r;
    logic             vend_ack;
    logic             coin_ack;
    logic             vend_go;
    logic             pay_two;
    logic             pay_one;
    logic             busy;
    logic [CHG_W-1:0] paid;
    logic             done;
    logic             fault;

    modport master (
        output d, r, vend_ack, coin_ack,
        input  vend_go, pay_two, pay_one, busy, paid, done, fault
    );

    modport slave (
        input  d, r, vend_ack, coin_ack,
        output vend_go, pay_two, pay_one, busy, paid, done, fault
    );
endinterface

// File: rtl/change_payout_ctrl.sv
// change_payout_ctrl
// Output side of the vending machine: releases the beverage, then pays the
// change greedily in $2 and $1 coins, each action being a four-phase
// request/acknowledge handshake. A mechanism that stalls longer than TIMEOUT
// cycles in a wait phase drives the block into a sticky FAULT.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : change_payout_ctrl_if.slave (d, r, acks in; requests/status out)
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for d; captures r into remain
// VEND     | vend_go high, waiting for vend_ack
// VEND_REL | vend_go low, waiting for vend_ack to drop
// SEL      | choose next coin ($2, $1) or finish
// PAY2     | pay_two high, waiting for coin_ack
// PAY1     | pay_one high, waiting for coin_ack
// COIN_REL | pay_* low, waiting for coin_ack to drop
// DONE     | done pulse, back to IDLE
// FAULT    | handshake timed out; left only by reset
module change_payout_ctrl #(
    parameter int CHG_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    change_payout_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        VEND,
        VEND_REL,
        SEL,
        PAY2,
        PAY1,
        COIN_REL,
        DONE,
        FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [CHG_W-1:0] remain, remain_nxt;
    logic [CHG_W-1:0] paid_q, paid_nxt;
    logic [TW-1:0]    tmr, tmr_nxt;
    logic             tmr_tc;

    // Last cycle a wait phase may spend before giving up.
    assign tmr_tc = (tmr == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        paid_nxt   = paid_q;
        tmr_nxt    = '0;   // cleared on every entry; only wait phases count up
        case (state)
            IDLE: begin
                if (bus.d) begin
                    remain_nxt = bus.r;
                    paid_nxt   = '0;
                    state_nxt  = VEND;
                end
            end
            VEND: begin
                if (bus.vend_ack)  state_nxt = VEND_REL;
                else if (tmr_tc)   state_nxt = FAULT;
                else               tmr_nxt   = tmr + TW'(1);
            end
            VEND_REL: begin
                if (!bus.vend_ack) state_nxt = SEL;
                else if (tmr_tc)   state_nxt = FAULT;
                else               tmr_nxt   = tmr + TW'(1);
            end
            SEL: begin
                if (remain >= CHG_W'(2))      state_nxt = PAY2;
                else if (remain == CHG_W'(1)) state_nxt = PAY1;
                else                          state_nxt = DONE;
            end
            PAY2: begin
                if (bus.coin_ack) begin
                    remain_nxt = remain - CHG_W'(2);
                    paid_nxt   = paid_q + CHG_W'(2);
                    state_nxt  = COIN_REL;
                end else if (tmr_tc) begin
                    state_nxt = FAULT;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            PAY1: begin
                if (bus.coin_ack) begin
                    remain_nxt = remain - CHG_W'(1);
                    paid_nxt   = paid_q + CHG_W'(1);
                    state_nxt  = COIN_REL;
                end else if (tmr_tc) begin
                    state_nxt = FAULT;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            COIN_REL: begin
                if (!bus.coin_ack) state_nxt = SEL;
                else if (tmr_tc)   state_nxt = FAULT;
                else               tmr_nxt   = tmr + TW'(1);
            end
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            remain <= '0;
            paid_q <= '0;
            tmr    <= '0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            paid_q <= paid_nxt;
            tmr    <= tmr_nxt;
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.vend_go <= 1'b0;
            bus.pay_two <= 1'b0;
            bus.pay_one <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.fault   <= 1'b0;
        end else begin
            bus.vend_go <= (state_nxt == VEND);
            bus.pay_two <= (state_nxt == PAY2);
            bus.pay_one <= (state_nxt == PAY1);
            bus.busy    <= (state_nxt != IDLE);
            bus.done    <= (state_nxt == DONE);
            bus.fault   <= (state_nxt == FAULT);
        end
    end

    assign bus.paid = paid_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
module tb_change_payout_ctrl;
    localparam int CHG_W   = 3;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    change_payout_ctrl_if #(.CHG_W(CHG_W)) bus();

    change_payout_ctrl #(.CHG_W(CHG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Mechanism model: acknowledges a request after a programmable delay and
    // releases the ack once the request has dropped.
    bit ack_en    = 1'b0;
    bit coin_mute = 1'b0;
    int vend_dly  = 0;
    int coin_dly  = 0;
    int vcnt      = 0;
    int ccnt      = 0;

    initial forever begin
        @(negedge clk);
        if (ack_en) begin
            if (bus.vend_go && !bus.vend_ack) begin
                if (vcnt >= vend_dly) begin bus.vend_ack = 1'b1; vcnt = 0; end
                else vcnt++;
            end else if (!bus.vend_go && bus.vend_ack) begin
                bus.vend_ack = 1'b0;
            end
            if (coin_mute) begin
                bus.coin_ack = 1'b0;
            end else if ((bus.pay_two || bus.pay_one) && !bus.coin_ack) begin
                if (ccnt >= coin_dly) begin bus.coin_ack = 1'b1; ccnt = 0; end
                else ccnt++;
            end else if (!bus.pay_two && !bus.pay_one && bus.coin_ack) begin
                bus.coin_ack = 1'b0;
            end
        end
    end

    // Observer: counts request pulses and done pulses, records each new
    // nonzero paid value, and checks request exclusivity every cycle.
    int               n_two = 0, n_one = 0, n_done = 0;
    logic [CHG_W-1:0] paid_log[$];
    logic             p_two = 1'b0, p_one = 1'b0, p_done = 1'b0;
    logic [CHG_W-1:0] p_paid = '0;

    initial forever begin
        @(negedge clk);
        check("req_exclusive", 32'($countones({bus.vend_go, bus.pay_two, bus.pay_one}) <= 1), 1);
        check("done_one_cycle", 32'(bus.done && p_done), 0);
        if (bus.pay_two && !p_two) n_two++;
        if (bus.pay_one && !p_one) n_one++;
        if (bus.done && !p_done)   n_done++;
        if (bus.paid !== p_paid && bus.paid != '0) paid_log.push_back(bus.paid);
        p_two  = bus.pay_two;
        p_one  = bus.pay_one;
        p_done = bus.done;
        p_paid = bus.paid;
    end

    function automatic logic [31:0] outs();
        return 32'({bus.vend_go, bus.pay_two, bus.pay_one, bus.busy, bus.paid, bus.done, bus.fault});
    endfunction

    // One complete transaction with change rv; inject=1 pulses a second
    // request (r=1) while the first $2 coin is being requested.
    task automatic run_txn(input int rv, input bit inject);
        int cyc;
        bit injected;
        int exp_two, exp_one, acc;
        int exp_log[$];
        @(negedge clk);
        n_two = 0; n_one = 0; n_done = 0;
        paid_log.delete();
        check("idle_before_req", 32'(bus.busy), 0);
        bus.d = 1'b1;
        bus.r = rv[CHG_W-1:0];
        @(negedge clk);
        bus.d = 1'b0;
        bus.r = CHG_W'($urandom);
        check("busy_latency", 32'(bus.busy), 1);
        check("vend_go_latency", 32'(bus.vend_go), 1);
        cyc = 0;
        injected = 1'b0;
        while (!bus.done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (inject && !injected && bus.pay_two) begin
                bus.d = 1'b1;
                bus.r = CHG_W'(1);
                injected = 1'b1;
            end else begin
                bus.d = 1'b0;
            end
        end
        bus.d = 1'b0;
        check("done_within_budget", 32'(cyc < 300), 1);
        @(negedge clk);
        check("busy_after_done", 32'(bus.busy), 0);
        check("done_dropped", 32'(bus.done), 0);

        // Reference: greedy change, as many $2 coins as fit, then a $1 if odd.
        exp_two = rv / 2;
        exp_one = rv % 2;
        acc = 0;
        for (int i = 0; i < exp_two; i++) begin acc += 2; exp_log.push_back(acc); end
        for (int i = 0; i < exp_one; i++) begin acc += 1; exp_log.push_back(acc); end

        check("done_pulses", n_done, 1);
        check("two_handshakes", n_two, exp_two);
        check("one_handshakes", n_one, exp_one);
        check("paid_final", 32'(bus.paid), rv);
        check("paid_steps", paid_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++)
            if (i < paid_log.size()) check("paid_step_value", 32'(paid_log[i]), exp_log[i]);
    endtask

    initial begin
        int cyc, hi;
        reset        = 1'b0;
        bus.d        = 1'b0;
        bus.r        = '0;
        bus.vend_ack = 1'b0;
        bus.coin_ack = 1'b0;

        // 1: reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.d        = 1'($urandom);
            bus.r        = CHG_W'($urandom);
            bus.vend_ack = 1'($urandom);
            bus.coin_ack = 1'($urandom);
            check("reset_outputs", outs(), 0);
        end
        @(negedge clk);
        bus.d = 1'b0; bus.vend_ack = 1'b0; bus.coin_ack = 1'b0;
        reset = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", outs(), 0);

        // 2: no change, slow chute
        vend_dly = 2; coin_dly = 0;
        run_txn(0, 1'b0);

        // 3: r=3, quick acks
        vend_dly = 0; coin_dly = 0;
        run_txn(3, 1'b0);

        // 4: r=4 with a request pulsed mid-payout, then a normal request
        coin_dly = 1;
        run_txn(4, 1'b1);
        run_txn(1, 1'b0);

        // random transactions, including r=5..7
        for (int k = 0; k < 8; k++) begin
            vend_dly = $urandom_range(0, 3);
            coin_dly = $urandom_range(0, 3);
            run_txn($urandom_range(0, 7), 1'b0);
        end
        run_txn(7, 1'b0);

        // 5: hopper never answers
        coin_mute = 1'b1; vend_dly = 0;
        @(negedge clk);
        bus.d = 1'b1; bus.r = CHG_W'(2);
        @(negedge clk);
        bus.d = 1'b0;
        cyc = 0;
        while (!bus.pay_two && cyc < 100) begin @(negedge clk); cyc++; end
        check("pay_two_reached", 32'(cyc < 100), 1);
        hi = 0;
        while (bus.pay_two && hi < 100) begin hi++; @(negedge clk); end
        check("timeout_len", hi, TIMEOUT);
        check("fault_set", 32'(bus.fault), 1);
        check("fault_busy", 32'(bus.busy), 1);
        check("fault_pay_two", 32'(bus.pay_two), 0);
        bus.d = 1'b1; bus.r = CHG_W'(1);
        repeat (4) @(negedge clk);
        bus.d = 1'b0;
        check("fault_sticky", 32'(bus.fault), 1);
        check("fault_busy_held", 32'(bus.busy), 1);
        check("fault_no_vend", 32'(bus.vend_go), 0);
        #2 reset = 1'b0;
        #1 check("fault_cleared_by_reset", outs(), 0);
        ack_en = 1'b0; coin_mute = 1'b0;
        bus.vend_ack = 1'b0; bus.coin_ack = 1'b0; vcnt = 0; ccnt = 0;
        @(negedge clk);
        reset = 1'b1;
        ack_en = 1'b1;

        // 6: reset in the middle of the first $2 coin
        coin_dly = 3;
        @(negedge clk);
        bus.d = 1'b1; bus.r = CHG_W'(4);
        @(negedge clk);
        bus.d = 1'b0;
        cyc = 0;
        while (!bus.pay_two && cyc < 100) begin @(negedge clk); cyc++; end
        check("pay_two_before_reset", 32'(bus.pay_two), 1);
        #2 reset = 1'b0;
        #1 check("async_drop_pay_two", 32'(bus.pay_two), 0);
        check("async_reset_outputs", outs(), 0);
        ack_en = 1'b0;
        bus.vend_ack = 1'b0; bus.coin_ack = 1'b0; vcnt = 0; ccnt = 0;
        @(negedge clk);
        reset = 1'b1;
        ack_en = 1'b1;
        coin_dly = 0;
        run_txn(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
